// File: rtl/sram_bus_adapter.sv
// Load/store front end for the 4-lane byte-writable SRAM: lane decode, sub-word extract, 2-entry response buffer.
// Define SRAM_BUS_ADAPTER_ERR_EN to flag misaligned / reserved-size requests instead of force-aligning them.
module sram_bus_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic                    req_wen,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    sram_en,
  output logic [3:0]              sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  logic [1:0]            count;
  logic                  rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_err  [2];

  logic       st_inflight;
  logic [1:0] st_off, st_size;
  logic       st_signed, st_wen, st_err;

  logic [1:0] req_off, req_esize;
  logic       req_err;
  logic       accept, pop, push, do_write, do_read;
  logic [2:0] occ_after_pop;

  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    req_err   = 1'b0;
    req_esize = req_size;
    req_off   = req_addr[1:0];
`ifdef SRAM_BUS_ADAPTER_ERR_EN
    req_err = (req_size == 2'd3) ||
              (req_size == 2'd1 && req_addr[0]) ||
              (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
    // Without error detection, size 3 acts as a word and low bits are dropped.
    if (req_size == 2'd3) req_esize = 2'd2;
    case (req_esize)
      2'd0:    req_off = req_addr[1:0];
      2'd1:    req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
`endif
  end

  assign pop           = resp_valid && resp_ready;
  assign occ_after_pop = {1'b0, count} + {2'b00, st_inflight} - {2'b00, pop};
  assign req_ready     = !reset && (occ_after_pop <= 3'd1);
  assign accept        = req_valid && req_ready;

  always_comb begin
    sram_en    = accept && !req_err;
    sram_addr  = reset ? '0 : req_addr[ADDR_WIDTH+1:2];
    sram_we    = 4'b0000;
    sram_wdata = '0;
    if (sram_en && req_wen) begin
      case (req_esize)
        2'd0:    sram_we = 4'b0001 << req_off;
        2'd1:    sram_we = req_off[1] ? 4'b1100 : 4'b0011;
        default: sram_we = 4'b1111;
      endcase
    end
    if (!reset) begin
      case (req_esize)
        2'd0:    sram_wdata = {4{req_wdata[7:0]}};
        2'd1:    sram_wdata = {2{req_wdata[15:0]}};
        default: sram_wdata = req_wdata;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_inflight <= 1'b0;
      st_off      <= 2'b00;
      st_size     <= 2'b00;
      st_signed   <= 1'b0;
      st_wen      <= 1'b0;
      st_err      <= 1'b0;
    end else begin
      st_inflight <= accept;
      if (accept) begin
        st_off    <= req_off;
        st_size   <= req_esize;
        st_signed <= req_signed;
        st_wen    <= req_wen;
        st_err    <= req_err;
      end
    end
  end

  always_comb begin
    case (st_off)
      2'd0:    rd_byte = sram_rdata[7:0];
      2'd1:    rd_byte = sram_rdata[15:8];
      2'd2:    rd_byte = sram_rdata[23:16];
      default: rd_byte = sram_rdata[31:24];
    endcase
    rd_half = st_off[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    push_data = '0;
    if (!st_wen && !st_err) begin
      case (st_size)
        2'd0:    push_data = {{24{st_signed && rd_byte[7]}}, rd_byte};
        2'd1:    push_data = {{16{st_signed && rd_half[15]}}, rd_half};
        default: push_data = sram_rdata;
      endcase
    end
  end

  // A reset in the response cycle discards the word coming back from the SRAM.
  assign push     = st_inflight && !reset;
  assign do_write = push && !(count == 2'd0 && resp_ready);
  assign do_read  = pop && (count != 2'd0);

  always_comb begin
    resp_valid = !reset && (count != 2'd0 || push);
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (!reset) begin
      if (count != 2'd0) begin
        resp_rdata = fifo_data[rd_ptr];
        resp_err   = fifo_err[rd_ptr];
      end else if (push) begin
        resp_rdata = push_data;
        resp_err   = st_err;
      end
    end
`ifndef SRAM_BUS_ADAPTER_ERR_EN
    resp_err = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= ~wr_ptr;
      if (do_read)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_write} - {1'b0, do_read};
    end
  end

  always_ff @(posedge clock) begin
    if (do_write) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= st_err;
    end
  end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Bench for sram_bus_adapter: behavioural SRAM, byte-level reference memory and an in-order response scoreboard.
module tb_sram_bus_adapter;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW+1:0] req_addr = '0;
  logic          req_wen = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  sram_bus_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr];
      for (int l = 0; l < 4; l++)
        if (sram_we[l]) sram_mem[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte memory plus queue of expected responses in acceptance order.
  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t        q[$];
  logic [7:0]  mbytes [0:(4<<AW)-1];
  int          pop_cycles[$];
  logic [31:0] pop_data[$];

  logic        last_en;
  logic [3:0]  last_we;
  logic [31:0] last_wd;
  logic [AW-1:0] last_addr;
  logic [31:0] last_resp_rdata;
  logic        last_resp_err;
  int          last_lat;
  int          pops = 0;

  int          m_nb, m_off, m_base, m_a;
  logic        m_err, m_exp_valid;
  logic [3:0]  m_we;
  logic [31:0] m_wd;
  longint      m_val;
  exp_t        m_e;

  always @(negedge clock) begin
    if (reset) begin
      chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
      chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("reset_sram_en", {31'b0, sram_en}, 32'd0);
      chk("reset_sram_we", {28'b0, sram_we}, 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_err", {31'b0, resp_err}, 32'd0);
      q.delete();
    end else begin
      m_exp_valid = (q.size() > 0) && (q[0].cyc < cyc);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_exp_valid});
      if (resp_valid && m_exp_valid) begin
        chk("resp_rdata", resp_rdata, q[0].rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
        if (resp_ready) begin
          last_resp_rdata = resp_rdata;
          last_resp_err   = resp_err;
          last_lat        = cyc - q[0].cyc;
          pop_cycles.push_back(cyc);
          pop_data.push_back(resp_rdata);
          pops++;
          void'(q.pop_front());
        end
      end
      chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() <= 1});
      if (req_valid && req_ready) begin
        m_a = int'(req_addr);
`ifdef SRAM_BUS_ADAPTER_ERR_EN
        m_err = (req_size == 3) || (req_size == 1 && m_a % 2 != 0) || (req_size == 2 && m_a % 4 != 0);
        m_nb  = (req_size == 3) ? 4 : (1 << req_size);
        m_off = m_a % 4;
`else
        m_err = 1'b0;
        m_nb  = (req_size >= 2) ? 4 : (1 << req_size);
        m_off = (m_a % 4) - ((m_a % 4) % m_nb);
`endif
        m_base = (m_a / 4) * 4;
        m_we = 4'b0;
        m_wd = '0;
        m_val = 0;
        if (!m_err && req_wen) begin
          for (int b = 0; b < m_nb; b++) begin
            mbytes[m_base + m_off + b] = req_wdata[8*b +: 8];
            m_we[m_off + b] = 1'b1;
          end
          for (int l = 0; l < 4; l++) m_wd[8*l +: 8] = req_wdata[8*(l % m_nb) +: 8];
        end
        if (!m_err && !req_wen) begin
          for (int b = 0; b < m_nb; b++) m_val = m_val + (longint'(mbytes[m_base + m_off + b]) << (8*b));
          if (req_signed && m_nb < 4 && m_val >= (longint'(1) << (8*m_nb - 1)))
            m_val = m_val - (longint'(1) << (8*m_nb));
        end
        chk("sram_en", {31'b0, sram_en}, {31'b0, !m_err});
        chk("sram_we", {28'b0, sram_we}, {28'b0, m_we});
        if (!m_err) chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, 32'(m_a / 4));
        if (!m_err && req_wen) chk("sram_wdata", sram_wdata, m_wd);
        last_en   = sram_en;
        last_we   = sram_we;
        last_wd   = sram_wdata;
        last_addr = sram_addr;
        m_e.rdata = m_val[31:0];
        m_e.err   = m_err;
        m_e.cyc   = cyc;
        q.push_back(m_e);
      end
      chk("occupancy_le_2", {31'b0, q.size() <= 2}, 32'd1);
    end
  end

  task automatic set_req(input int a, input logic w, input logic [1:0] s, input logic sg, input logic [31:0] d);
    req_addr = (AW+2)'(a); req_wen = w; req_size = s; req_signed = sg; req_wdata = d;
  endtask

  task automatic issue(input int a, input logic w, input logic [1:0] s, input logic sg, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    @(posedge clock); #1;
    set_req(a, w, s, sg, d);
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
      if (acc) break;
    end
    req_valid = 1'b0;
    chk("issue_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int bp_addr [4] = '{'h010, 'h013, 'h020, 'h022};
  logic [1:0] bp_size [4] = '{2'd2, 2'd0, 2'd2, 2'd1};
  int idx;
  logic acc;
  int pops0;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    issue('h010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    chk("word_store_we", {28'b0, last_we}, 32'hF);
    chk("word_store_addr", {{(32-AW){1'b0}}, last_addr}, 32'd4);
    chk("word_store_wdata", last_wd, 32'hDEADBEEF);
    wait_cyc(2);
    chk("word_store_resp", last_resp_rdata, 32'h0);
    issue('h010, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_cyc(2);
    chk("word_load", last_resp_rdata, 32'hDEADBEEF);
    chk("word_load_err", {31'b0, last_resp_err}, 32'd0);
    chk("word_load_latency", 32'(last_lat), 32'd1);

    issue('h013, 1'b1, 2'd0, 1'b0, 32'h00000080);
    chk("byte_store_we", {28'b0, last_we}, 32'h8);
    chk("byte_store_wdata", last_wd, 32'h80808080);
    wait_cyc(2);
    issue('h013, 1'b0, 2'd0, 1'b1, 32'h0);
    wait_cyc(2);
    chk("byte_load_signed", last_resp_rdata, 32'hFFFFFF80);
    issue('h013, 1'b0, 2'd0, 1'b0, 32'h0);
    wait_cyc(2);
    chk("byte_load_unsigned", last_resp_rdata, 32'h00000080);

    issue('h022, 1'b1, 2'd1, 1'b0, 32'hFFFF1234);
    chk("half_store_we", {28'b0, last_we}, 32'hC);
    chk("half_store_wdata", last_wd, 32'h12341234);
    wait_cyc(2);
    issue('h022, 1'b0, 2'd1, 1'b1, 32'h0);
    wait_cyc(2);
    chk("half_load_signed_pos", last_resp_rdata, 32'h00001234);
    issue('h020, 1'b1, 2'd1, 1'b0, 32'h00008001);
    wait_cyc(2);
    issue('h020, 1'b0, 2'd1, 1'b1, 32'h0);
    wait_cyc(2);
    chk("half_load_signed_neg", last_resp_rdata, 32'hFFFF8001);

    issue('h011, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_cyc(2);
`ifdef SRAM_BUS_ADAPTER_ERR_EN
    chk("misaligned_load_en", {31'b0, last_en}, 32'd0);
    chk("misaligned_load_err", {31'b0, last_resp_err}, 32'd1);
    chk("misaligned_load_rdata", last_resp_rdata, 32'h0);
`else
    chk("aligned_word_load", last_resp_rdata, 32'h80ADBEEF);
    chk("aligned_word_err", {31'b0, last_resp_err}, 32'd0);
`endif
    issue('h021, 1'b1, 2'd1, 1'b0, 32'h00005555);
`ifdef SRAM_BUS_ADAPTER_ERR_EN
    chk("misaligned_store_en", {31'b0, last_en}, 32'd0);
    wait_cyc(2);
    chk("misaligned_store_err", {31'b0, last_resp_err}, 32'd1);
`else
    chk("aligned_half_store_we", {28'b0, last_we}, 32'h3);
    wait_cyc(2);
`endif
    issue('h020, 1'b0, 2'd2, 1'b0, 32'h0);
    wait_cyc(2);
`ifdef SRAM_BUS_ADAPTER_ERR_EN
    chk("word_after_bad_store", last_resp_rdata, 32'h12348001);
`else
    chk("word_after_aligned_store", last_resp_rdata, 32'h12345555);
`endif

    // Backpressure: four back-to-back loads with the response side stalled.
    resp_ready = 1'b0;
    pop_cycles.delete();
    pop_data.delete();
    @(posedge clock); #1;
    idx = 0;
    set_req(bp_addr[0], 1'b0, bp_size[0], 1'b1, 32'h0);
    req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        if (idx < 4) set_req(bp_addr[idx], 1'b0, bp_size[idx], 1'b1, 32'h0);
      end
    end
    chk("bp_accepted_stalled", 32'(idx), 32'd2);
    @(negedge clock);
    chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    for (int k = 0; k < 10 && idx < 4; k++) begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        if (idx < 4) set_req(bp_addr[idx], 1'b0, bp_size[idx], 1'b1, 32'h0);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    wait_cyc(3);
    chk("bp_resp_count", 32'(pop_cycles.size()), 32'd4);
    if (pop_cycles.size() == 4) begin
      chk("bp_back_to_back", 32'(pop_cycles[3] - pop_cycles[0]), 32'd3);
      chk("bp_resp0", pop_data[0], 32'h80ADBEEF);
      chk("bp_resp1", pop_data[1], 32'hFFFFFF80);
      chk("bp_resp3", pop_data[3], 32'h00001234);
    end

    // Reset the cycle after a load is accepted: its response must never appear.
    pops0 = pops;
    issue('h010, 1'b0, 2'd2, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset2", {31'b0, req_ready}, 32'd1);
    chk("no_resp_after_reset", {31'b0, resp_valid}, 32'd0);
    wait_cyc(3);
    chk("dropped_resp", 32'(pops - pops0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/sram_bus_adapter.md
Name: sram_bus_adapter

Overview:
- Request/response front end for the single-port byte-writable on-chip SRAM (4 lanes x 8 bits, 1-cycle registered read).
- Accepts byte-addressed load/store requests on a valid/ready channel and generates the SRAM word address and byte-lane write mask.
- Replicates store data into the correct lanes and captures the SRAM read word one cycle later.
- Extracts and sign/zero-extends the loaded sub-word, and returns one response per request through a 2-entry buffer with valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width. The byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, fixed data width (4 byte lanes). Other values are unsupported.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte-lane write enables
- sram_addr  out  ADDR_WIDTH  SRAM word address, = req_addr[ADDR_WIDTH+1:2]
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Reset: req_ready=0 while reset is high, resp_valid=0, inflight=0, buffer count=0, resp_rdata=0, resp_err=0.
  - A reset during an access drops the in-flight word; the sram_rdata arriving the next cycle is discarded.
  - sram_* outputs are 0 during reset.
- Acceptance:
  - pop = resp_valid && resp_ready.
  - req_ready = !reset && (count + inflight - pop) <= 1, where count is the number of buffered responses (0..2).
  - This sustains one request per cycle when resp_ready is held at 1.
- SRAM drive (combinational from the accepted request):
  - sram_en = accept && !err.
  - sram_we = 0 for loads and errors.
  - Byte store: sram_we = 1 << addr[1:0], wdata[7:0] replicated to all 4 lanes.
  - Half store: sram_we = 4'b0011 or 4'b1100 by addr[1], wdata[15:0] replicated to both halves.
  - Word store: sram_we = 4'b1111.
- Error condition: size 3, half with addr[0]=1, or word with addr[1:0] != 0.
- Stage registers: on accept, capture inflight=1 plus addr[1:0], size, signed, wen, err. Otherwise inflight=0.
- Response generation (cycle after accept):
  - Select the lane of sram_rdata by the stored addr[1:0].
  - Extend to 32 bits per the stored signed bit.
  - Stores and errors produce rdata=0; err carries through.
  - Push the result into a 2-entry FIFO.
- Latency: accept at cycle N -> resp_valid at N+1 at the earliest (the FIFO output registers the pushed entry, or is bypassed combinationally when empty — choose bypass). Responses are in order.
- Simultaneous push and pop: count unchanged, order preserved.
- Overflow is impossible by construction of req_ready. The bench asserts count <= 2.
- resp_rdata and resp_err hold stable while resp_valid=1 and resp_ready=0.

Optional Feature:
- Macro: SRAM_BUS_ADAPTER_ERR_EN.
- Defined: misalignment and reserved-size detection as described above.
- Undefined: err is always 0, resp_err is tied 0, low address bits below the access size are ignored (forced alignment), and size 3 is treated as word.

Test Plan:
- Word store addr 0x010 data 0xDEADBEEF -> sram_we=1111, sram_addr=4. Word load 0x010 -> resp_rdata=0xDEADBEEF, err=0, one cycle after accept.
- Byte store 0x80 to addr 0x013, then signed byte load 0x013 -> 0xFFFFFF80; unsigned load -> 0x00000080. Store cycle shows sram_we=1000, sram_wdata=0x80808080.
- Half store 0x1234 to addr 0x022 -> sram_we=1100, wdata=0x12341234. Signed half load 0x022 -> 0x00001234.
- With ERR_EN: word load at addr 0x011 -> sram_en=0, resp_err=1, resp_rdata=0. Half store at 0x021 -> no SRAM write, err=1. Without the macro: the same load returns the word at 0x010.
- Backpressure: resp_ready=0 while issuing 4 back-to-back loads -> exactly 2 accepted, then req_ready=0. Raise resp_ready -> remaining loads accepted, 4 responses in order, 1 per cycle.
- Reset asserted the cycle after a load accept -> no response ever appears, resp_valid=0, and req_ready returns to 1 the cycle after reset deasserts.
